// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_issuer
// Purpose  : Buffers ALU commands in a small FIFO and issues them one at a
//            time to an external ALU. Each command is driven onto
//            opcode/data_a/data_b, the ALU output-enable is pulsed for one
//            cycle, and the ALU bus is captured into a result register. That
//            register is held under a valid/ready handshake until the
//            consumer accepts it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH      command FIFO depth in entries (power of two, >= 2)
// Ports
//   clk        clock; all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   cmd_valid  upstream command valid
//   cmd_ready  command can be accepted (FIFO not full)
//   cmd_opcode command opcode [2:0]
//   cmd_a      command operand A [3:0]
//   cmd_b      command operand B [3:0]
//   opcode     opcode driven to the ALU [2:0]
//   data_a     operand A driven to the ALU [3:0]
//   data_b     operand B driven to the ALU [3:0]
//   enable     ALU output-enable, high for one cycle per command
//   alu_bus    ALU result bus [3:0]
//   res_valid  captured result valid
//   res_ready  consumer accepts the result
//   res_data   captured result [3:0]
//   res_opcode opcode that produced res_data [2:0]
// ============================================================================
module alu_cmd_issuer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_opcode,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic [2:0] opcode,
  output logic [3:0] data_a,
  output logic [3:0] data_b,
  output logic       enable,
  input  logic [3:0] alu_bus,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic [2:0] res_opcode
);

  localparam int c_ptr_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w   = $clog2(DEPTH + 1);
  localparam int c_entry_w = 11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  logic [c_entry_w-1:0] r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic                 r_fresh;

  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_avail;
  logic [c_entry_w-1:0] w_head;

  assign w_full    = (r_count == c_cnt_w'(DEPTH));
  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && !w_full;
  assign w_head    = r_mem[r_rd_ptr];

  // An entry written at the last edge is not yet offered to the issue FSM.
  // That one-cycle staging gives the accept-to-enable latency of two edges
  // and the accept-to-result latency of three. The freshly written entry is
  // always the tail, so holding it back never reorders commands.
  assign w_avail = (r_count > c_cnt_w'(1)) ||
                   ((r_count == c_cnt_w'(1)) && !r_fresh);

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_opcode, cmd_a, cmd_b};
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_fresh  <= 1'b0;
    end else begin
      r_fresh <= w_push;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Issue FSM
  // --------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nxt;
  logic   w_capture;
  logic   w_release;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_avail) begin
          w_pop       = 1'b1;
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        w_capture   = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        // res_valid is always high in HOLD, so res_ready alone completes
        // the handshake. A waiting command is issued without passing
        // through IDLE.
        if (res_ready) begin
          w_release = 1'b1;
          if (w_avail) begin
            w_pop       = 1'b1;
            w_state_nxt = S_DRIVE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Decoded from the state register so that reset drops it immediately.
  assign enable = (r_state == S_DRIVE);

  // --------------------------------------------------------------------------
  // ALU operand registers: loaded on each pop, held otherwise
  // --------------------------------------------------------------------------
  logic [2:0] r_opcode;
  logic [3:0] r_data_a;
  logic [3:0] r_data_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= '0;
      r_data_a <= '0;
      r_data_b <= '0;
    end else if (w_pop) begin
      r_opcode <= w_head[10:8];
      r_data_a <= w_head[7:4];
      r_data_b <= w_head[3:0];
    end
  end

  assign opcode = r_opcode;
  assign data_a = r_data_a;
  assign data_b = r_data_b;

  // --------------------------------------------------------------------------
  // Result register
  // --------------------------------------------------------------------------
  logic       r_res_valid;
  logic [3:0] r_res_data;
  logic [2:0] r_res_opcode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_opcode <= '0;
    end else begin
      if (w_capture) begin
        r_res_valid  <= 1'b1;
        r_res_data   <= alu_bus;
        r_res_opcode <= r_opcode;
      end else if (w_release) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_opcode = r_res_opcode;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_issuer
// Purpose  : Self-checking bench for alu_cmd_issuer. An ALU stub drives the
//            bus while enable is high and drives noise otherwise. A queue
//            model tracks accepted, issued and returned commands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_issuer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_opcode = '0;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic [2:0] opcode;
  logic [3:0] data_a;
  logic [3:0] data_b;
  logic       enable;
  logic [3:0] alu_bus;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data;
  logic [2:0] res_opcode;
  logic [3:0] junk = 4'h9;

  alu_cmd_issuer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .opcode     (opcode),
    .data_a     (data_a),
    .data_b     (data_b),
    .enable     (enable),
    .alu_bus    (alu_bus),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_opcode (res_opcode)
  );

  always #5 clk = ~clk;

  // ALU stub: OR, XOR and NOT-B are decoded; other codes give zero.
  function automatic logic [3:0] alu_fn(input logic [2:0] op, input logic [3:0] a,
                                        input logic [3:0] b);
    case (op)
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      3'b110:  return ~b;
      default: return 4'b0000;
    endcase
  endfunction

  assign alu_bus = enable ? alu_fn(opcode, data_a, data_b) : junk;

  typedef struct packed {logic [2:0] op; logic [3:0] a; logic [3:0] b;} cmd_t;
  typedef struct packed {logic [2:0] op; logic [3:0] r;} res_t;
  typedef struct {logic [2:0] op; logic [3:0] a; logic [3:0] b; logic [3:0] res;} vec_t;

  cmd_t       acc_q[$];   // accepted, not yet issued (FIFO contents)
  res_t       res_q[$];   // issued, result not yet handed over
  logic [3:0] res_log[$]; // results handed over, in order
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_en     = 0;
  logic       last_push;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, note the handshakes that the coming edge
  // will complete, then update the model and compare just after the edge.
  task automatic step(input logic v, input logic [2:0] op, input logic [3:0] a,
                      input logic [3:0] b, input logic rr);
    logic hs_push, hs_res, p_valid, p_en;
    logic [3:0] p_data;
    logic [2:0] p_op;
    cmd_t e;
    res_t r;
    cmd_valid = v; cmd_opcode = op; cmd_a = a; cmd_b = b; res_ready = rr;
    #1;
    hs_push = cmd_valid && cmd_ready;
    hs_res  = res_valid && res_ready;
    p_valid = res_valid; p_data = res_data; p_op = res_opcode; p_en = enable;
    @(posedge clk);
    #1;
    junk = 4'($urandom);
    last_push = hs_push;
    if (hs_res) begin
      chk("result_expected", 32'(res_q.size() != 0), 32'd1);
      if (res_q.size() != 0) begin
        r = res_q.pop_front();
        chk("res_data", 32'(p_data), 32'(r.r));
        chk("res_opcode", 32'(p_op), 32'(r.op));
      end
      res_log.push_back(p_data);
    end else if (p_valid) begin
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_data", 32'(res_data), 32'(p_data));
      chk("hold_opcode", 32'(res_opcode), 32'(p_op));
    end
    if (p_en) begin
      chk("enable_one_cycle", 32'(enable), 32'd0);
      chk("valid_after_drive", 32'(res_valid), 32'd1);
    end
    if (hs_push) acc_q.push_back({op, a, b});
    if (enable) begin
      n_en++;
      chk("issue_nonempty", 32'(acc_q.size() != 0), 32'd1);
      if (acc_q.size() != 0) begin
        e = acc_q.pop_front();
        chk("issue_opcode", 32'(opcode), 32'(e.op));
        chk("issue_a", 32'(data_a), 32'(e.a));
        chk("issue_b", 32'(data_b), 32'(e.b));
        res_q.push_back({e.op, alu_fn(e.op, e.a, e.b)});
      end
    end
    chk("cmd_ready", 32'(cmd_ready), 32'(acc_q.size() < DEPTH));
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, 3'b0, 4'h0, 4'h0, rr);
  endtask

  vec_t vecs[10];
  int   accepted;

  initial begin
    vecs[0] = '{3'b001, 4'b0101, 4'b0011, 4'b0111};
    vecs[1] = '{3'b010, 4'b1100, 4'b1010, 4'b0110};
    vecs[2] = '{3'b110, 4'b1001, 4'b0011, 4'b1100};
    vecs[3] = '{3'b000, 4'b1111, 4'b1111, 4'b0000};
    vecs[4] = '{3'b011, 4'b1010, 4'b0101, 4'b0000};
    vecs[5] = '{3'b100, 4'b0111, 4'b0001, 4'b0000};
    vecs[6] = '{3'b101, 4'b1111, 4'b0000, 4'b0000};
    vecs[7] = '{3'b111, 4'b0011, 4'b1100, 4'b0000};
    vecs[8] = '{3'b001, 4'b0000, 4'b0000, 4'b0000};
    vecs[9] = '{3'b010, 4'b1111, 4'b1111, 4'b0000};

    // Reset values while rst_n is held low.
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_operands", {21'd0, opcode, data_a, data_b}, 32'd0);
    chk("rst_result", {25'd0, res_opcode, res_data}, 32'd0);
    rst_n = 1'b1;
    idle(2, 1'b0);

    // Single-op latency for each table vector.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      chk("vec_accept", 32'(last_push), 32'd1);
      chk("vec_en_N", 32'(enable), 32'd0);
      step(1'b0, 3'b0, 4'h0, 4'h0, 1'b0);
      chk("vec_en_N1", 32'(enable), 32'd0);
      step(1'b0, 3'b0, 4'h0, 4'h0, 1'b0);
      chk("vec_en_N2", 32'(enable), 32'd1);
      chk("vec_res_valid_N2", 32'(res_valid), 32'd0);
      step(1'b0, 3'b0, 4'h0, 4'h0, 1'b0);
      chk("vec_en_N3", 32'(enable), 32'd0);
      chk("vec_res_valid_N3", 32'(res_valid), 32'd1);
      chk("vec_res_data", 32'(res_data), 32'(vecs[i].res));
      chk("vec_res_opcode", 32'(res_opcode), 32'(vecs[i].op));
      step(1'b0, 3'b0, 4'h0, 4'h0, 1'b1);
      chk("vec_res_cleared", 32'(res_valid), 32'd0);
    end

    // Back-to-back XOR then NOT with res_ready high.
    res_log.delete();
    n_en = 0;
    step(1'b1, 3'b010, 4'b1100, 4'b1010, 1'b1);
    step(1'b1, 3'b110, 4'b0110, 4'b0011, 1'b1);
    idle(10, 1'b1);
    chk("b2b_count", 32'(res_log.size()), 32'd2);
    chk("b2b_enables", 32'(n_en), 32'd2);
    if (res_log.size() == 2) begin
      chk("b2b_first", 32'(res_log[0]), 32'b0110);
      chk("b2b_second", 32'(res_log[1]), 32'b1100);
    end

    // Full FIFO: DEPTH + 2 offered with res_ready low.
    res_log.delete();
    accepted = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      for (int t = 0; t < 8; t++) begin
        step(1'b1, 3'b010, 4'(i), 4'hF, 1'b0);
        if (last_push) break;
      end
      if (last_push) accepted++;
    end
    chk("full_accepts", 32'(accepted), 32'(DEPTH + 1));
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    idle(30, 1'b1);
    chk("full_drain_count", 32'(res_log.size()), 32'(DEPTH + 1));
    for (int i = 0; i < res_log.size(); i++) chk("full_order", 32'(res_log[i]), 32'(4'(i) ^ 4'hF));

    // Push and pop in the same cycle with two entries queued.
    res_log.delete();
    step(1'b1, 3'b001, 4'h1, 4'h2, 1'b0);
    step(1'b1, 3'b010, 4'h3, 4'h5, 1'b0);
    step(1'b1, 3'b110, 4'h0, 4'h6, 1'b0);
    idle(3, 1'b0);
    chk("simul_count_before", 32'(dut.r_count), 32'd2);
    step(1'b1, 3'b001, 4'h8, 4'h0, 1'b1);
    chk("simul_accept", 32'(last_push), 32'd1);
    chk("simul_count_after", 32'(dut.r_count), 32'd2);
    idle(20, 1'b1);
    chk("simul_drain_count", 32'(res_log.size()), 32'd4);
    if (res_log.size() == 4) begin
      chk("simul_r0", 32'(res_log[0]), 32'h3);
      chk("simul_r1", 32'(res_log[1]), 32'h6);
      chk("simul_r2", 32'(res_log[2]), 32'h9);
      chk("simul_r3", 32'(res_log[3]), 32'h8);
    end

    // Reset during DRIVE with two commands queued.
    step(1'b1, 3'b001, 4'h1, 4'h1, 1'b0);
    step(1'b1, 3'b010, 4'h2, 4'h2, 1'b0);
    step(1'b1, 3'b110, 4'h3, 4'h3, 1'b0);
    for (int t = 0; t < 5 && !enable; t++) step(1'b0, 3'b0, 4'h0, 4'h0, 1'b0);
    chk("mid_in_drive", 32'(enable), 32'd1);
    chk("mid_queued", 32'(acc_q.size()), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_enable", 32'(enable), 32'd0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    acc_q.delete();
    res_q.delete();
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 3'b0, 4'h0, 4'h0, 1'b1);
      chk("post_rst_enable", 32'(enable), 32'd0);
      chk("post_rst_res_valid", 32'(res_valid), 32'd0);
    end

    // Randomized traffic against the queue model.
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 2) != 0), 3'($urandom), 4'($urandom), 4'($urandom),
           1'($urandom_range(0, 2) != 0));
    end
    idle(40, 1'b1);
    chk("rand_fifo_drained", 32'(acc_q.size()), 32'd0);
    chk("rand_results_drained", 32'(res_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
